// File: rtl/crypto_round_sequencer.sv
// Round sequencer for the block-cipher datapath: encrypt/decrypt strobe sequencing with settle gaps.
// Optional `abort` input is present only when CRYPTO_SEQ_ABORT_EN is defined.
module crypto_round_sequencer #(
    parameter int unsigned ROUNDS        = 10,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bgn,
    input  logic [1:0]  mode,
`ifdef CRYPTO_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [10:0] ctrl,
    output logic        inv,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] LAST_ROUND  = 4'(ROUNDS);
    localparam logic [2:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 3'd0 : 3'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_KEY_ADD0,
        S_KEY_ADD,
        S_SAVE_STEP,
        S_SHIFT_STEP,
        S_SAVE,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_KEY_SUB,
        S_OUT_DATA,
        S_OUT_KEY,
        S_FIN,
        S_SETTLE
    } state_t;

    state_t      state, state_d;
    state_t      ret, ret_d;
    state_t      succ;
    logic [2:0]  cnt, cnt_d;
    logic [10:0] ctrl_d;
    logic        reject;
    logic        abort_hit;

    // Successor of the current operation state; inv selects the decrypt ordering.
    always_comb begin
        succ = S_IDLE;
        case (state)
            S_LOAD:       succ = S_KEY_ADD0;
            S_KEY_ADD0:   succ = inv ? S_SHIFT_STEP : S_SAVE_STEP;
            S_SAVE_STEP:  succ = S_SUB;
            S_SHIFT_STEP: succ = S_SUB;
            S_SUB:        succ = inv ? S_KEY_SUB : S_SHIFT;
            S_SHIFT:      succ = (round == LAST_ROUND) ? S_KEY_SUB : S_MIX;
            S_MIX:        succ = inv ? S_SAVE : S_KEY_SUB;
            S_SAVE:       succ = S_SHIFT_STEP;
            S_KEY_SUB:    succ = S_KEY_ADD;
            S_KEY_ADD: begin
                if (inv) succ = (round == 4'd0) ? S_OUT_DATA : S_MIX;
                else     succ = (round == LAST_ROUND) ? S_OUT_DATA : S_SAVE_STEP;
            end
            S_OUT_DATA:   succ = S_OUT_KEY;
            S_OUT_KEY:    succ = S_FIN;
            default:      succ = S_IDLE;
        endcase
    end

    always_comb begin
        state_d   = state;
        ret_d     = ret;
        cnt_d     = cnt;
        reject    = 1'b0;
        abort_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (bgn) begin
                    if (mode == 2'b01 || mode == 2'b10) state_d = S_LOAD;
                    else                                reject  = 1'b1;
                end
            end
            S_FIN:    state_d = S_IDLE;
            S_SETTLE: begin
                if (cnt == 3'd0) state_d = ret;
                else             cnt_d   = cnt - 3'd1;
            end
            default: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = succ;
                end else begin
                    state_d = S_SETTLE;
                    ret_d   = succ;
                    cnt_d   = SETTLE_LAST;
                end
            end
        endcase
`ifdef CRYPTO_SEQ_ABORT_EN
        if (abort && state != S_IDLE && state != S_FIN) begin
            state_d   = S_IDLE;
            abort_hit = 1'b1;
        end
`endif

        ctrl_d = '0;
        case (state_d)
            S_LOAD:       ctrl_d[0]  = 1'b1;
            S_KEY_ADD0,
            S_KEY_ADD:    ctrl_d[1]  = 1'b1;
            S_SAVE_STEP: begin
                ctrl_d[2] = 1'b1;
                ctrl_d[7] = 1'b1;
            end
            S_SHIFT_STEP: begin
                ctrl_d[4] = 1'b1;
                ctrl_d[7] = 1'b1;
            end
            S_SAVE:       ctrl_d[2]  = 1'b1;
            S_SUB:        ctrl_d[3]  = 1'b1;
            S_SHIFT:      ctrl_d[4]  = 1'b1;
            S_MIX:        ctrl_d[5]  = 1'b1;
            S_KEY_SUB:    ctrl_d[6]  = 1'b1;
            S_OUT_DATA:   ctrl_d[8]  = 1'b1;
            S_OUT_KEY:    ctrl_d[9]  = 1'b1;
            S_FIN:        ctrl_d[10] = 1'b1;
            default:      ctrl_d     = '0;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ret   <= S_IDLE;
            cnt   <= '0;
            ctrl  <= '0;
            inv   <= 1'b0;
            round <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            ret   <= ret_d;
            cnt   <= cnt_d;
            ctrl  <= ctrl_d;
            busy  <= (state_d != S_IDLE);
            done  <= (state_d == S_FIN);
            err   <= reject | abort_hit;
            if (abort_hit) begin
                inv   <= 1'b0;
                round <= '0;
            end else if (state == S_IDLE && state_d == S_LOAD) begin
                inv   <= (mode == 2'b10);
                round <= (mode == 2'b10) ? LAST_ROUND : 4'd0;
            end else if (state_d == S_IDLE) begin
                inv <= 1'b0;
            end else if (state_d == S_SAVE_STEP) begin
                round <= round + 4'd1;
            end else if (state_d == S_SHIFT_STEP) begin
                round <= round - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Scoreboard bench for crypto_round_sequencer: default instance plus a ROUNDS=1/SETTLE_CYCLES=0 instance.
// Exercises the abort path when CRYPTO_SEQ_ABORT_EN is defined.
module tb_crypto_round_sequencer;

    localparam int unsigned R = 10;
    localparam int unsigned S = 1;

    localparam logic [10:0] C_LOAD  = 11'h001;
    localparam logic [10:0] C_KA    = 11'h002;
    localparam logic [10:0] C_SAVE  = 11'h004;
    localparam logic [10:0] C_SUB   = 11'h008;
    localparam logic [10:0] C_SHIFT = 11'h010;
    localparam logic [10:0] C_MIX   = 11'h020;
    localparam logic [10:0] C_KSUB  = 11'h040;
    localparam logic [10:0] C_STEP  = 11'h080;
    localparam logic [10:0] C_OD    = 11'h100;
    localparam logic [10:0] C_OK    = 11'h200;
    localparam logic [10:0] C_FIN   = 11'h400;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [3:0]  round;
        logic        busy;
        logic        inv;
        logic        done;
        logic        err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, bgn, bgn1, abort;
    logic [1:0]  mode, mode1;
    logic [10:0] ctrl, ctrl1;
    logic        inv, inv1, busy, busy1, done, done1, err, err1;
    logic [3:0]  round, round1;

    always #5 clk = ~clk;

    crypto_round_sequencer #(.ROUNDS(R), .SETTLE_CYCLES(S)) dut (
`ifdef CRYPTO_SEQ_ABORT_EN
        .abort (abort),
`endif
        .clk   (clk),
        .rst   (rst),
        .bgn   (bgn),
        .mode  (mode),
        .ctrl  (ctrl),
        .inv   (inv),
        .round (round),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    crypto_round_sequencer #(.ROUNDS(1), .SETTLE_CYCLES(0)) dut1 (
`ifdef CRYPTO_SEQ_ABORT_EN
        .abort (1'b0),
`endif
        .clk   (clk),
        .rst   (rst),
        .bgn   (bgn1),
        .mode  (mode1),
        .ctrl  (ctrl1),
        .inv   (inv1),
        .round (round1),
        .busy  (busy1),
        .done  (done1),
        .err   (err1)
    );

    obs_t        q[$];
    obs_t        q1[$];
    logic [3:0]  mr, mr1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc, exp_done, exp_saves;
    int unsigned steps, mixes, saves, busy_cnt;
    bit          mon_en = 1'b0;
    bit          stats_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_op(input logic [10:0] c, input logic iv, input logic fin);
        obs_t t;
        t = '{ctrl: c, round: mr, busy: 1'b1, inv: iv, done: fin, err: 1'b0};
        q.push_back(t);
        if (!fin) begin
            for (int unsigned i = 0; i < S; i++) begin
                t = '{ctrl: 11'd0, round: mr, busy: 1'b1, inv: iv, done: 1'b0, err: 1'b0};
                q.push_back(t);
            end
        end
    endtask

    task automatic push_seq(input bit dec);
        if (!dec) begin
            mr = 4'd0;
            push_op(C_LOAD, 1'b0, 1'b0);
            push_op(C_KA, 1'b0, 1'b0);
            for (int k = 1; k <= int'(R); k++) begin
                mr = 4'(k);
                push_op(C_SAVE | C_STEP, 1'b0, 1'b0);
                push_op(C_SUB, 1'b0, 1'b0);
                push_op(C_SHIFT, 1'b0, 1'b0);
                if (k != int'(R)) push_op(C_MIX, 1'b0, 1'b0);
                push_op(C_KSUB, 1'b0, 1'b0);
                push_op(C_KA, 1'b0, 1'b0);
            end
            exp_done  = (6 * R + 3) * (1 + S) + 1;
            exp_saves = R;
        end else begin
            mr = 4'(R);
            push_op(C_LOAD, 1'b1, 1'b0);
            push_op(C_KA, 1'b1, 1'b0);
            for (int k = int'(R) - 1; k >= 0; k--) begin
                mr = 4'(k);
                push_op(C_SHIFT | C_STEP, 1'b1, 1'b0);
                push_op(C_SUB, 1'b1, 1'b0);
                push_op(C_KSUB, 1'b1, 1'b0);
                push_op(C_KA, 1'b1, 1'b0);
                if (k != 0) begin
                    push_op(C_MIX, 1'b1, 1'b0);
                    push_op(C_SAVE, 1'b1, 1'b0);
                end
            end
            exp_done  = (6 * R + 2) * (1 + S) + 1;
            exp_saves = R - 1;
        end
        push_op(C_OD, dec, 1'b0);
        push_op(C_OK, dec, 1'b0);
        push_op(C_FIN, dec, 1'b1);
    endtask

    task automatic push_err();
        obs_t t;
        t = '{ctrl: 11'd0, round: mr, busy: 1'b0, inv: 1'b0, done: 1'b0, err: 1'b1};
        q.push_back(t);
    endtask

    task automatic start(input logic [1:0] m);
        bgn = 1'b1;
        mode = m;
        push_seq(m == 2'b10);
        start_cyc = cyc;
        steps = 0;
        mixes = 0;
        saves = 0;
        busy_cnt = 0;
        stats_on = 1'b1;
        tick();
        bgn = 1'b0;
        mode = 2'b00;
    endtask

    // Hand-written expected sequences for the single-round, no-settle instance.
    task automatic start1(input bit dec);
        logic [10:0] ce [10];
        logic [3:0]  re [10];
        int unsigned n;
        obs_t        t;
        if (!dec) begin
            ce = '{C_LOAD, C_KA, C_SAVE | C_STEP, C_SUB, C_SHIFT, C_KSUB, C_KA, C_OD, C_OK, C_FIN};
            re = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
            n  = 10;
        end else begin
            ce = '{C_LOAD, C_KA, C_SHIFT | C_STEP, C_SUB, C_KSUB, C_KA, C_OD, C_OK, C_FIN, 11'd0};
            re = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
            n  = 9;
        end
        for (int unsigned i = 0; i < n; i++) begin
            t = '{ctrl: ce[i], round: re[i], busy: 1'b1, inv: dec, done: (i == n - 1), err: 1'b0};
            q1.push_back(t);
        end
        mr1 = dec ? 4'd0 : 4'd1;
        bgn1 = 1'b1;
        mode1 = dec ? 2'b10 : 2'b01;
        tick();
        bgn1 = 1'b0;
        mode1 = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && q1.size() == 0) break;
            tick();
        end
        tick();
    endtask

    obs_t e, g, e1, g1;

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            cyc++;
            if (q.size() != 0) e = q.pop_front();
            else e = '{ctrl: 11'd0, round: mr, busy: 1'b0, inv: 1'b0, done: 1'b0, err: 1'b0};
            g = '{ctrl: ctrl, round: round, busy: busy, inv: inv, done: done, err: err};
            check("ctrl", 32'(g.ctrl), 32'(e.ctrl));
            check("round", 32'(g.round), 32'(e.round));
            check("busy_inv_done_err", 32'({g.busy, g.inv, g.done, g.err}),
                  32'({e.busy, e.inv, e.done, e.err}));
            if (q1.size() != 0) e1 = q1.pop_front();
            else e1 = '{ctrl: 11'd0, round: mr1, busy: 1'b0, inv: 1'b0, done: 1'b0, err: 1'b0};
            g1 = '{ctrl: ctrl1, round: round1, busy: busy1, inv: inv1, done: done1, err: err1};
            check("r1_ctrl", 32'(g1.ctrl), 32'(e1.ctrl));
            check("r1_round", 32'(g1.round), 32'(e1.round));
            check("r1_busy_inv_done_err", 32'({g1.busy, g1.inv, g1.done, g1.err}),
                  32'({e1.busy, e1.inv, e1.done, e1.err}));
            if (stats_on) begin
                steps    += 32'(ctrl[7]);
                mixes    += 32'(ctrl[5]);
                saves    += 32'(ctrl[2]);
                busy_cnt += 32'(busy);
                if (done) begin
                    check("done_cycle", cyc - start_cyc, exp_done);
                    check("step_count", steps, R);
                    check("mix_count", mixes, R - 1);
                    check("save_count", saves, exp_saves);
                    check("busy_cycles", busy_cnt, exp_done);
                    stats_on = 1'b0;
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        bgn = 1'b0;
        mode = 2'b00;
        bgn1 = 1'b0;
        mode1 = 2'b00;
        abort = 1'b0;
        mr = 4'd0;
        mr1 = 4'd0;
        repeat (3) tick();
        check("reset_ctrl", 32'(ctrl), 32'd0);
        check("reset_inv", 32'(inv), 32'd0);
        check("reset_round", 32'(round), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_r1_ctrl", 32'(ctrl1), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();

        // Encrypt with a stray bgn mid-run, then decrypt started in the IDLE cycle after FIN.
        start(2'b01);
        repeat (28) tick();
        bgn = 1'b1;
        mode = 2'b10;
        tick();
        bgn = 1'b0;
        mode = 2'b00;
        repeat (98) tick();
        start(2'b10);
        drain();
        check("decrypt_done_seen", 32'(stats_on), 32'd0);

        // Rejected starts.
        bgn = 1'b1;
        mode = 2'b11;
        push_err();
        tick();
        mode = 2'b00;
        push_err();
        tick();
        bgn = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in cycle 50, then a clean restart.
        start(2'b01);
        repeat (49) tick();
        rst = 1'b0;
        #1;
        check("arst_ctrl", 32'(ctrl), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_round", 32'(round), 32'd0);
        check("arst_done_err", 32'({done, err}), 32'd0);
        q.delete();
        mr = 4'd0;
        mr1 = 4'd0;
        stats_on = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        start(2'b01);
        drain();
        check("restart_done_seen", 32'(stats_on), 32'd0);

        // Single-round instance, both directions.
        start1(1'b0);
        drain();
        start1(1'b1);
        drain();

`ifdef CRYPTO_SEQ_ABORT_EN
        start(2'b01);
        repeat (39) tick();
        abort = 1'b1;
        q.delete();
        mr = 4'd0;
        stats_on = 1'b0;
        push_err();
        tick();
        abort = 1'b0;
        repeat (3) tick();
        start(2'b01);
        drain();
        check("post_abort_done_seen", 32'(stats_on), 32'd0);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/crypto_round_sequencer.md
# crypto_round_sequencer

Parametrised successor to the cryptographic core control unit: a round sequencer driving the block-cipher datapath (key add, substitution, shift, mix-column, key schedule, I/O) for a configurable number of rounds and configurable settle delay. It owns the round counter internally (no external `fin_counter`), adds `busy`/`done`/`err` handshaking, and exposes the current round index to the key schedule.

## Interface
- `ROUNDS`, 10, number of cipher rounds; legal 1..15.
- `SETTLE_CYCLES`, 1, idle cycles inserted after every operation state; legal 0..7.
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low.
- `bgn`  input  1  start request, sampled only in IDLE.
- `mode`  input  2  01 encrypt, 10 decrypt, sampled with `bgn`.
- `ctrl`  output  11  registered operation strobes: [0] LOAD, [1] KEY_ADD, [2] SAVE, [3] SUB, [4] SHIFT, [5] MIX, [6] KEY_SUB, [7] STEP, [8] OUT_DATA, [9] OUT_KEY, [10] FIN.
- `inv`  output  1  level, 1 for whole decrypt operation (datapath selects inverse S-box/shift/mix).
- `round`  output  4  current round index.
- `busy`  output  1  high from LOAD cycle through FIN cycle inclusive.
- `done`  output  1  one-cycle pulse, coincident with `ctrl[10]`.
- `err`  output  1  one-cycle pulse on rejected start (or abort, see Configuration).

## Operation
- Reset: state IDLE; `ctrl`=0, `inv`=0, `round`=0, `busy`=0, `done`=0, `err`=0.
- IDLE: `bgn`=1 with `mode`∈{01,10} → LOAD; `mode`∈{00,11} → stay IDLE, `err` pulses next cycle. `bgn` outside IDLE ignored.
- Every operation state asserts exactly its `ctrl` bit(s) for one cycle, then SETTLE_CYCLES cycles with `ctrl`=0; `round` stable during settle.
- Encrypt (`inv`=0): LOAD (round←0), KEY_ADD; then per round r=1..ROUNDS: SAVE+STEP (same cycle, round←round+1), SUB, SHIFT, MIX (skipped when round==ROUNDS), KEY_SUB, KEY_ADD; then OUT_DATA, OUT_KEY, FIN.
- Decrypt (`inv`=1): LOAD (round←ROUNDS), KEY_ADD; then per round: SHIFT+STEP (round←round−1), SUB, KEY_SUB, KEY_ADD, then if round≠0: MIX, SAVE, loop; if round==0: OUT_DATA, OUT_KEY, FIN.
- FIN has no settle; returns to IDLE next edge, `inv` cleared there. `round` holds final value (ROUNDS encrypt, 0 decrypt) until next LOAD.
- `mode` changes after the start edge have no effect.

## Timing
- `ctrl`, `busy`, `inv` registered from next state: LOAD visible in cycle 1 = cycle immediately after the edge sampling `bgn`.
- Encrypt: FIN/`done` in cycle (6·ROUNDS+3)(1+SETTLE_CYCLES)+1; defaults → cycle 127.
- Decrypt: FIN/`done` in cycle (6·ROUNDS+2)(1+SETTLE_CYCLES)+1; defaults → cycle 125.
- `round` updates on same edge that raises STEP (visible in the STEP cycle).
- `bgn` high in the cycle after FIN starts a new operation: LOAD one cycle after that sampling edge (no dead cycle beyond IDLE).
- Async reset mid-operation: all outputs zero immediately, no `done`, no `err`.
- ROUNDS=1 encrypt: no MIX; decrypt: no MIX/SAVE.

## Configuration
- `CRYPTO_SEQ_ABORT_EN` defined: adds input `abort` (1 bit). `abort`=1 sampled in any non-IDLE state except FIN → next cycle IDLE, `ctrl`=0, `busy`=0, `inv`=0, `round`=0, `err` pulses one cycle, no `done`. `abort` in IDLE/FIN ignored; `abort` and `bgn` together in IDLE → start proceeds.
- Undefined: no `abort` port; operations run to FIN only.

## Test plan
- Defaults, encrypt, `bgn`=1/`mode`=01 for one cycle → LOAD cycle 1, 10 STEP strobes, round 1..10, 9 MIX, `done` cycle 127, `busy` 127 cycles.
- Defaults, decrypt `mode`=10 → `inv`=1 throughout, round 10→0, 9 MIX, 9 SAVE, `done` cycle 125, `inv`=0 after.
- ROUNDS=1, SETTLE_CYCLES=0 encrypt → exact ctrl sequence LOAD,KEY_ADD,SAVE+STEP,SUB,SHIFT,KEY_SUB,KEY_ADD,OUT_DATA,OUT_KEY,FIN, `done` cycle 10.
- `bgn`=1 with `mode`=11 → `err` one cycle, `busy` stays 0, no LOAD; `bgn` pulsed mid-encrypt → no effect on sequence/latency.
- `rst` low at cycle 50 of encrypt → all outputs 0 asynchronously; new start after release completes normally in 127 cycles.
- With `CRYPTO_SEQ_ABORT_EN`: `abort` at cycle 40 → `err` pulse cycle 41, `busy`=0, `round`=0, no `done`; following start runs full length.
